// File: rtl/ascon_perm_engine_pkg.sv
// Shared types for the ASCON permutation engine: state layout, round constants,
// XOR-down select encoding and default round counts.
package ascon_pack;

  // S0 occupies the most significant 64 bits, matching {S0,S1,S2,S3,S4}.
  typedef logic [0:4][63:0] type_state;

  localparam int unsigned ROUNDS_A_DEF = 12;
  localparam int unsigned ROUNDS_B_DEF = 6;

  typedef enum logic [1:0] {
    XdKey       = 2'b00,
    XdDomain    = 2'b01,
    XdKeyDomain = 2'b10,
    XdNone      = 2'b11
  } xd_sel_e;

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

endpackage

// File: rtl/ascon_perm_engine_round.sv
// One combinational ASCON round: constant addition, bit-sliced 5-bit S-box layer,
// linear diffusion.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ {56'h0, rc(round_i)};
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    state_o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    state_o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    state_o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    state_o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequencing ASCON p^a / p^b with XOR-up on load and XOR-down after the last round.
// Define ASCON_PERM_ABORT_EN to add the abort_i port.
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int unsigned UNROLL   = 1,
  parameter int unsigned ROUNDS_A = ROUNDS_A_DEF,
  parameter int unsigned ROUNDS_B = ROUNDS_B_DEF,
  parameter int unsigned DATA_W   = 128
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  type_state         state_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [127:0]      key_i,
  input  logic              ena_xor_up_i,
  input  logic              ena_xor_down_i,
  input  logic [1:0]        sel_xor_down_i,
`ifdef ASCON_PERM_ABORT_EN
  input  logic              abort_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output type_state         state_o
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end
  if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_div
    $error("ascon_perm_engine: round counts must be divisible by UNROLL");
  end
  if (ROUNDS_A == 0 || ROUNDS_A > 12) begin : g_bad_ra
    $error("ascon_perm_engine: ROUNDS_A must be 1..12");
  end
  if (ROUNDS_B != 6 && ROUNDS_B != 8) begin : g_bad_rb
    $error("ascon_perm_engine: ROUNDS_B must be 6 or 8");
  end
  if (DATA_W != 64 && DATA_W != 128) begin : g_bad_dw
    $error("ascon_perm_engine: DATA_W must be 64 or 128");
  end

  localparam logic [3:0] RStartA = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RStartB = 4'(12 - ROUNDS_B);
  localparam logic [3:0] Step    = 4'(UNROLL);

  typedef enum logic [0:0] {StIdle, StRun} st_e;

  st_e          st_q, st_d;
  logic [3:0]   cnt_q, cnt_d;
  type_state    reg_q, reg_d;
  logic         done_q, done_d;
  logic         xd_en_q, xd_en_d;
  xd_sel_e      xd_sel_q, xd_sel_d;
  logic [127:0] key_q, key_d;

  logic         abort;
  logic         last;
  logic [127:0] up_mask;
  type_state    loaded;
  type_state    xored;
  type_state    chain [UNROLL+1];

`ifdef ASCON_PERM_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  assign chain[0] = reg_q;
  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state_i (chain[k]),
      .round_i (cnt_q + 4'(k)),
      .state_o (chain[k+1])
    );
  end

  assign last = (cnt_q + Step) == 4'd12;

  // Data lands on the MSBs of {S0,S1} regardless of DATA_W.
  always_comb begin
    up_mask = ena_xor_up_i ? (128'(data_i) << (128 - DATA_W)) : 128'h0;
    loaded  = state_i;
    loaded[0] = state_i[0] ^ up_mask[127:64];
    loaded[1] = state_i[1] ^ up_mask[63:0];
  end

  always_comb begin
    xored = chain[UNROLL];
    if (xd_en_q) begin
      case (xd_sel_q)
        XdKey: begin
          xored[3] = chain[UNROLL][3] ^ key_q[127:64];
          xored[4] = chain[UNROLL][4] ^ key_q[63:0];
        end
        XdDomain: xored[4] = chain[UNROLL][4] ^ 64'h1;
        XdKeyDomain: begin
          xored[3] = chain[UNROLL][3] ^ key_q[127:64];
          xored[4] = chain[UNROLL][4] ^ key_q[63:0] ^ 64'h1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    reg_d    = reg_q;
    done_d   = 1'b0;
    xd_en_d  = xd_en_q;
    xd_sel_d = xd_sel_q;
    key_d    = key_q;
    case (st_q)
      StIdle: begin
        if (start_i) begin
          st_d     = StRun;
          cnt_d    = mode_i ? RStartB : RStartA;
          reg_d    = loaded;
          xd_en_d  = ena_xor_down_i;
          xd_sel_d = xd_sel_e'(sel_xor_down_i);
          key_d    = key_i;
        end
      end
      StRun: begin
        if (abort) begin
          st_d  = StIdle;
          cnt_d = '0;
        end else if (last) begin
          st_d   = StIdle;
          cnt_d  = '0;
          reg_d  = xored;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + Step;
          reg_d = chain[UNROLL];
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      reg_q    <= '0;
      done_q   <= 1'b0;
      xd_en_q  <= 1'b0;
      xd_sel_q <= XdKey;
      key_q    <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      done_q   <= done_d;
      xd_en_q  <= xd_en_d;
      xd_sel_q <= xd_sel_d;
      key_q    <= key_d;
    end
  end

  assign busy_o  = (st_q == StRun);
  assign done_o  = done_q;
  assign state_o = reg_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Scoreboard bench for ascon_perm_engine: one UNROLL=1 and one UNROLL=2 instance,
// checked against a table-driven S-box reference model.
module tb_ascon_perm_engine;
  import ascon_pack::*;

  localparam int RA = 12;
  localparam int RB = 6;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam type_state IV = {64'h00001000808c0001, 64'h6cb10ad9ca912f80,
                              64'h691aed630e81901f, 64'h0c4c36a20853217c,
                              64'h46487b3e06d9d7a8};
  localparam type_state IV2 = {64'h243f6a8885a308d3, 64'h13198a2e03707344,
                               64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
                               64'h452821e638d01377};
  localparam logic [127:0] KEY  = 128'h691aed630e81901f6cb10ad9ca912f80;
  localparam logic [127:0] DATA = 128'h0123456789abcdef0123456789abcdef;

  typedef struct {
    type_state st;
    int        due;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   start;
  logic [1:0]   busy;
  logic [1:0]   done;
  logic         mode_in;
  type_state    st_in;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         up_in;
  logic         dn_in;
  logic [1:0]   sel_in;
  type_state    st_o0;
  type_state    st_o1;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort_in;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  sb_t q0[$];
  sb_t q1[$];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_perm_engine #(.UNROLL(1)) u_dut1 (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start[0]),
    .mode_i         (mode_in),
    .state_i        (st_in),
    .data_i         (data_in),
    .key_i          (key_in),
    .ena_xor_up_i   (up_in),
    .ena_xor_down_i (dn_in),
    .sel_xor_down_i (sel_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i        (abort_in),
`endif
    .busy_o         (busy[0]),
    .done_o         (done[0]),
    .state_o        (st_o0)
  );

  ascon_perm_engine #(.UNROLL(2)) u_dut2 (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start[1]),
    .mode_i         (mode_in),
    .state_i        (st_in),
    .data_i         (data_in),
    .key_i          (key_in),
    .ena_xor_up_i   (up_in),
    .ena_xor_down_i (dn_in),
    .sel_xor_down_i (sel_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort_i        (1'b0),
`endif
    .busy_o         (busy[1]),
    .done_o         (done[1]),
    .state_o        (st_o1)
  );

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic type_state model(input type_state s_in, input int n,
                                      input logic [127:0] up, input logic dn,
                                      input logic [1:0] sel, input logic [127:0] key);
    type_state s;
    logic [4:0] col;
    s = s_in;
    s[0] = s[0] ^ up[127:64];
    s[1] = s[1] ^ up[63:0];
    for (int r = 12 - n; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ 8'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]} = col;
      end
      s[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
      s[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
      s[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
      s[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
      s[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    end
    if (dn) begin
      if (sel == 2'b00 || sel == 2'b10) begin
        s[3] = s[3] ^ key[127:64];
        s[4] = s[4] ^ key[63:0];
      end
      if (sel == 2'b01 || sel == 2'b10) s[4] = s[4] ^ 64'h1;
    end
    return s;
  endfunction

  // Call just after a negedge; returns at the negedge following the accepting edge.
  task automatic start_op(input int d, input logic mode, input type_state st,
                          input logic [127:0] data, input logic up, input logic dn,
                          input logic [1:0] sel, input logic [127:0] key);
    sb_t e;
    int n;
    int u;
    n = mode ? RB : RA;
    u = (d == 0) ? 1 : 2;
    mode_in = mode;
    st_in   = st;
    data_in = data;
    key_in  = key;
    up_in   = up;
    dn_in   = dn;
    sel_in  = sel;
    start[d] = 1'b1;
    e.st  = model(st, n, up ? data : 128'h0, dn, sel, key);
    e.due = cyc + 1 + n / u;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    mode_in = ~mode_in;
    st_in   = ~st_in;
    data_in = ~data_in;
    key_in  = ~key_in;
    up_in   = ~up_in;
    dn_in   = ~dn_in;
    sel_in  = ~sel_in;
  endtask

  task automatic wait_done(input int d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done[d] && k < 40);
    if (!done[d]) check("done_timeout", {319'h0, done[d]}, 320'h1);
  endtask

  always @(negedge clk) begin : mon
    sb_t e;
    if (done[0]) begin
      if (q0.size() == 0) check("d0_spurious_done", {319'h0, done[0]}, 320'h0);
      else begin
        e = q0.pop_front();
        check("d0_state", st_o0, e.st);
        check("d0_latency", cyc, e.due);
      end
    end
    if (done[1]) begin
      if (q1.size() == 0) check("d1_spurious_done", {319'h0, done[1]}, 320'h0);
      else begin
        e = q1.pop_front();
        check("d1_state", st_o1, e.st);
        check("d1_latency", cyc, e.due);
      end
    end
  end

  initial begin
    rst = 1'b1;
    start = 2'b00;
    mode_in = 1'b0;
    st_in = '0;
    data_in = '0;
    key_in = '0;
    up_in = 1'b0;
    dn_in = 1'b0;
    sel_in = 2'b00;
`ifdef ASCON_PERM_ABORT_EN
    abort_in = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_state0", st_o0, '0);
    check("rst_state1", st_o1, '0);
    check("rst_busy", busy, 2'b00);
    check("rst_done", done, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // p^12 with key XOR-down, UNROLL=1
    start_op(0, 1'b0, IV, 128'h0, 1'b0, 1'b1, 2'b00, KEY);
    check("d0_busy_run", busy[0], 1'b1);
    wait_done(0);
    check("d0_busy_at_done", busy[0], 1'b0);

    // p^6 with XOR-up, UNROLL=2
    @(negedge clk);
    start_op(1, 1'b1, IV, DATA, 1'b1, 1'b0, 2'b00, KEY);
    wait_done(1);

    // Back-to-back with an ignored mid-run start
    @(negedge clk);
    start_op(0, 1'b1, IV2, DATA, 1'b1, 1'b1, 2'b10, KEY);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);
    start_op(0, 1'b0, IV, 128'h0, 1'b0, 1'b1, 2'b01, KEY);
    check("d0_b2b_gap", done[0], 1'b0);
    check("d0_b2b_busy", busy[0], 1'b1);
    wait_done(0);
    start_op(1, 1'b0, IV2, DATA, 1'b1, 1'b1, 2'b00, KEY);
    wait_done(1);
    start_op(1, 1'b1, IV, DATA, 1'b1, 1'b1, 2'b10, KEY);
    check("d1_b2b_gap", done[1], 1'b0);
    wait_done(1);

    // Asynchronous reset mid-run
    @(negedge clk);
    start_op(0, 1'b0, IV, DATA, 1'b1, 1'b1, 2'b00, KEY);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", st_o0, '0);
    check("arst_busy", busy[0], 1'b0);
    check("arst_done", done[0], 1'b0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_op(0, 1'b1, IV, DATA, 1'b1, 1'b1, 2'b00, KEY);
    wait_done(0);

    // XOR-down selects and disabled XOR-down on the same input
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      start_op(1, 1'b1, IV2, 128'h0, 1'b0, 1'b1, 2'(s), KEY);
      wait_done(1);
    end
    @(negedge clk);
    start_op(1, 1'b1, IV2, 128'h0, 1'b0, 1'b0, 2'b00, KEY);
    wait_done(1);

`ifdef ASCON_PERM_ABORT_EN
    @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check("idle_abort_busy", busy[0], 1'b0);
    start_op(0, 1'b0, IV, 128'h0, 1'b0, 1'b1, 2'b00, KEY);
    repeat (2) @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    q0.delete();
    check("abort_busy", busy[0], 1'b0);
    check("abort_done", done[0], 1'b0);
    repeat (15) @(negedge clk);
    start_op(0, 1'b0, IV2, DATA, 1'b1, 1'b1, 2'b10, KEY);
    wait_done(0);
`endif

    repeat (3) @(negedge clk);
    check("d0_pending", q0.size(), 0);
    check("d1_pending", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
